// File: rtl/traffic_request_conditioner.sv
// rtl/traffic_request_conditioner.sv - request sync/debounce/latch and light monitor; TRAFFIC_REQ_WATCHDOG_EN adds starvation flags
module traffic_request_conditioner #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int PRESENCE_CYCLES = 3,
    parameter int WAIT_LIMIT      = 60
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       NS_loop_raw,
    input  logic       EW_loop_raw,
    input  logic       NS_ped_raw,
    input  logic       EW_ped_raw,
    input  logic [2:0] NS_light,
    input  logic [2:0] EW_light,
    input  logic [2:0] NS_ped_light,
    input  logic [2:0] EW_ped_light,
    output logic       NS_car_detect,
    output logic       EW_car_detect,
    output logic       NS_ped_button,
    output logic       EW_ped_button,
    output logic       fault,
    output logic [1:0] fault_code,
    output logic       NS_starved,
    output logic       EW_starved
);
    localparam int DW = $clog2(DEBOUNCE_CYCLES);
    localparam int PW = $clog2(PRESENCE_CYCLES + 1);
    localparam logic [2:0] RED   = 3'b100;
    localparam logic [2:0] GREEN = 3'b001;

    function automatic logic is_legal(input logic [2:0] l);
        return (l == 3'b100) || (l == 3'b010) || (l == 3'b001);
    endfunction

    // bit order: [0] NS loop, [1] EW loop, [2] NS ped, [3] EW ped
    logic [3:0] raw_vec;
    logic [3:0] sync1;
    logic [3:0] sync2;

    logic [1:0][DW-1:0] deb_cnt;
    logic [1:0]         deb;
    logic [1:0]         deb_d;
    logic [1:0]         ped_req;
    logic [1:0][PW-1:0] pres_cnt;
    logic [1:0]         car_req;
    logic [1:0]         light_green;
    logic [1:0]         ped_green;
    logic               invalid;
    logic               conflict;

    assign raw_vec     = {EW_ped_raw, NS_ped_raw, EW_loop_raw, NS_loop_raw};
    assign light_green = {EW_light == GREEN, NS_light == GREEN};
    assign ped_green   = {EW_ped_light == GREEN, NS_ped_light == GREEN};
    assign invalid     = !is_legal(NS_light) || !is_legal(EW_light) ||
                         !is_legal(NS_ped_light) || !is_legal(EW_ped_light);
    assign conflict    = (NS_light != RED) && (EW_light != RED);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1      <= '0;
            sync2      <= '0;
            deb_cnt    <= '0;
            deb        <= '0;
            deb_d      <= '0;
            ped_req    <= '0;
            pres_cnt   <= '0;
            car_req    <= '0;
            fault      <= 1'b0;
            fault_code <= 2'b00;
        end else begin
            sync1 <= raw_vec;
            sync2 <= sync1;
            deb_d <= deb;
            for (int a = 0; a < 2; a++) begin
                if (sync2[2+a] != deb[a]) begin
                    if (deb_cnt[a] == DW'(DEBOUNCE_CYCLES - 1)) begin
                        deb[a]     <= sync2[2+a];
                        deb_cnt[a] <= '0;
                    end else begin
                        deb_cnt[a] <= deb_cnt[a] + 1'b1;
                    end
                end else begin
                    deb_cnt[a] <= '0;
                end
                // a walk already in progress swallows the press
                if (ped_green[a])
                    ped_req[a] <= 1'b0;
                else if (deb[a] && !deb_d[a])
                    ped_req[a] <= 1'b1;
                if (!sync2[a])
                    pres_cnt[a] <= '0;
                else if (pres_cnt[a] != PW'(PRESENCE_CYCLES))
                    pres_cnt[a] <= pres_cnt[a] + 1'b1;
                // saturated count keeps the set term live so the call re-arms after green
                if (light_green[a])
                    car_req[a] <= 1'b0;
                else if (sync2[a] && (pres_cnt[a] >= PW'(PRESENCE_CYCLES - 1)))
                    car_req[a] <= 1'b1;
            end
            if (!fault && (invalid || conflict)) begin
                fault      <= 1'b1;
                fault_code <= {conflict, invalid};
            end
        end
    end

    assign NS_car_detect = car_req[0];
    assign EW_car_detect = car_req[1];
    assign NS_ped_button = ped_req[0];
    assign EW_ped_button = ped_req[1];

`ifdef TRAFFIC_REQ_WATCHDOG_EN
    localparam int WW = $clog2(WAIT_LIMIT + 1);
    logic [1:0][WW-1:0] wait_cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wait_cnt <= '0;
        end else begin
            for (int a = 0; a < 2; a++) begin
                if ((car_req[a] || ped_req[a]) && !light_green[a]) begin
                    if (wait_cnt[a] != WW'(WAIT_LIMIT))
                        wait_cnt[a] <= wait_cnt[a] + 1'b1;
                end else begin
                    wait_cnt[a] <= '0;
                end
            end
        end
    end

    assign NS_starved = (wait_cnt[0] == WW'(WAIT_LIMIT));
    assign EW_starved = (wait_cnt[1] == WW'(WAIT_LIMIT));
`else
    assign NS_starved = 1'b0;
    assign EW_starved = 1'b0;
`endif

endmodule

// File: tb/tb_traffic_request_conditioner.sv
// tb/tb_traffic_request_conditioner.sv - self-checking bench for traffic_request_conditioner
module tb_traffic_request_conditioner;
    localparam int D = 4;
    localparam int P = 3;
    localparam int W = 60;
    localparam logic [2:0] RED = 3'b100;
    localparam logic [2:0] YEL = 3'b010;
    localparam logic [2:0] GRN = 3'b001;

    logic       clk;
    logic       reset_n;
    logic       NS_loop_raw, EW_loop_raw, NS_ped_raw, EW_ped_raw;
    logic [2:0] NS_light, EW_light, NS_ped_light, EW_ped_light;
    logic       NS_car_detect, EW_car_detect, NS_ped_button, EW_ped_button;
    logic       fault;
    logic [1:0] fault_code;
    logic       NS_starved, EW_starved;

    int checks = 0;
    int errors = 0;
    int edge_n = 0;

    traffic_request_conditioner #(
        .DEBOUNCE_CYCLES(D),
        .PRESENCE_CYCLES(P),
        .WAIT_LIMIT(W)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .NS_loop_raw(NS_loop_raw),
        .EW_loop_raw(EW_loop_raw),
        .NS_ped_raw(NS_ped_raw),
        .EW_ped_raw(EW_ped_raw),
        .NS_light(NS_light),
        .EW_light(EW_light),
        .NS_ped_light(NS_ped_light),
        .EW_ped_light(EW_ped_light),
        .NS_car_detect(NS_car_detect),
        .EW_car_detect(EW_car_detect),
        .NS_ped_button(NS_ped_button),
        .EW_ped_button(EW_ped_button),
        .fault(fault),
        .fault_code(fault_code),
        .NS_starved(NS_starved),
        .EW_starved(EW_starved)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [1:0] act, input logic [1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: raw inputs seen two edges late, run lengths as plain integers.
    logic [3:0] m_hist [2] = '{4'b0, 4'b0};
    logic [1:0] m_deb = '0, m_deb_prev = '0, m_ped = '0, m_car = '0, m_starved = '0;
    int         m_run [2] = '{0, 0};
    int         m_hi  [2] = '{0, 0};
    int         m_wait[2] = '{0, 0};
    logic       m_fault = 1'b0;
    logic [1:0] m_code = 2'b00;

    function automatic logic legal(input logic [2:0] l);
        return (l == RED) || (l == YEL) || (l == GRN);
    endfunction

    always @(posedge clk) begin
        logic [1:0] lg, pg;
        logic       s_ped, s_loop, inv, conf;
        if (!reset_n) begin
            m_hist = '{4'b0, 4'b0};
            m_deb = '0; m_deb_prev = '0; m_ped = '0; m_car = '0; m_starved = '0;
            m_run = '{0, 0}; m_hi = '{0, 0}; m_wait = '{0, 0};
            m_fault = 1'b0; m_code = 2'b00;
        end else begin
            lg = {EW_light == GRN, NS_light == GRN};
            pg = {EW_ped_light == GRN, NS_ped_light == GRN};
            for (int a = 0; a < 2; a++) begin
`ifdef TRAFFIC_REQ_WATCHDOG_EN
                if ((m_car[a] || m_ped[a]) && !lg[a])
                    m_wait[a] = (m_wait[a] < W) ? m_wait[a] + 1 : W;
                else
                    m_wait[a] = 0;
                m_starved[a] = (m_wait[a] == W);
`endif
                s_ped  = m_hist[1][2+a];
                s_loop = m_hist[1][a];
                if (pg[a]) m_ped[a] = 1'b0;
                else if (m_deb[a] && !m_deb_prev[a]) m_ped[a] = 1'b1;
                m_deb_prev[a] = m_deb[a];
                if (s_ped != m_deb[a]) begin
                    m_run[a]++;
                    if (m_run[a] == D) begin
                        m_deb[a] = s_ped;
                        m_run[a] = 0;
                    end
                end else begin
                    m_run[a] = 0;
                end
                m_hi[a] = s_loop ? m_hi[a] + 1 : 0;
                if (lg[a]) m_car[a] = 1'b0;
                else if (m_hi[a] >= P) m_car[a] = 1'b1;
            end
            m_hist[1] = m_hist[0];
            m_hist[0] = {EW_ped_raw, NS_ped_raw, EW_loop_raw, NS_loop_raw};
            inv  = !legal(NS_light) || !legal(EW_light) || !legal(NS_ped_light) || !legal(EW_ped_light);
            conf = (NS_light != RED) && (EW_light != RED);
            if (!m_fault && (inv || conf)) begin
                m_fault = 1'b1;
                m_code  = {conf, inv};
            end
        end
    end

    always @(posedge clk) begin
        #1;
        chk("NS_car_detect", {1'b0, NS_car_detect}, {1'b0, m_car[0]});
        chk("EW_car_detect", {1'b0, EW_car_detect}, {1'b0, m_car[1]});
        chk("NS_ped_button", {1'b0, NS_ped_button}, {1'b0, m_ped[0]});
        chk("EW_ped_button", {1'b0, EW_ped_button}, {1'b0, m_ped[1]});
        chk("fault", {1'b0, fault}, {1'b0, m_fault});
        chk("fault_code", fault_code, m_code);
        chk("NS_starved", {1'b0, NS_starved}, {1'b0, m_starved[0]});
        chk("EW_starved", {1'b0, EW_starved}, {1'b0, m_starved[1]});
    end

    task automatic tick();
        @(posedge clk);
        #2;
        edge_n++;
    endtask

    task automatic run_to(input int n);
        while (edge_n < n) tick();
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        NS_loop_raw = 0; EW_loop_raw = 0; NS_ped_raw = 0; EW_ped_raw = 0;
        NS_light = RED; EW_light = RED; NS_ped_light = RED; EW_ped_light = RED;
        tick();
        tick();
        reset_n = 1'b1;
        edge_n = 0;
    endtask

    initial begin
        logic [1:0] exp_starve;
        do_reset();
        run_to(2);
        chk("reset_outputs", {1'b0, NS_car_detect | EW_car_detect | NS_ped_button | EW_ped_button | fault}, 2'd0);
        chk("reset_code", fault_code, 2'b00);

        // held NS button: one request, cleared by walk, not re-raised
        do_reset();
        run_to(9);  NS_ped_raw = 1;
        run_to(15); chk("ns_ped_e15", {1'b0, NS_ped_button}, 2'd0);
        run_to(16); chk("ns_ped_e16", {1'b0, NS_ped_button}, 2'd1);
        run_to(30); chk("ns_ped_e30", {1'b0, NS_ped_button}, 2'd1);
        NS_ped_light = GRN;
        run_to(31); chk("ns_ped_clr", {1'b0, NS_ped_button}, 2'd0);
        run_to(34); NS_ped_light = RED;
        run_to(45); chk("ns_ped_held", {1'b0, NS_ped_button}, 2'd0);
        NS_ped_raw = 0;

        // EW glitch, EW loop call, green clear and re-arm
        do_reset();
        run_to(2);  EW_ped_raw = 1;
        run_to(4);  EW_loop_raw = 1;
        run_to(5);  EW_ped_raw = 0;
        run_to(8);  chk("ew_car_e8", {1'b0, EW_car_detect}, 2'd0);
        run_to(9);  chk("ew_car_e9", {1'b0, EW_car_detect}, 2'd1);
        run_to(20); chk("ew_glitch", {1'b0, EW_ped_button}, 2'd0);
        EW_light = GRN;
        run_to(21); chk("ew_car_clr", {1'b0, EW_car_detect}, 2'd0);
        run_to(24); EW_light = RED;
        run_to(25); chk("ew_car_rearm", {1'b0, EW_car_detect}, 2'd1);

        // conflict fault, then sticky code
        do_reset();
        run_to(20); chk("fault_e20", {1'b0, fault}, 2'd0);
        NS_light = GRN; EW_light = YEL;
        run_to(21); chk("fault_e21", {1'b0, fault}, 2'd1);
        chk("code_conflict", fault_code, 2'b10);
        run_to(23); NS_light = 3'b111;
        run_to(26); chk("code_sticky", fault_code, 2'b10);

        do_reset();
        NS_ped_light = 3'b000;
        run_to(1);  chk("code_invalid", fault_code, 2'b01);

        do_reset();
        NS_light = 3'b111; EW_light = GRN;
        run_to(1);  chk("code_both", fault_code, 2'b11);

        // reset in the middle of a press loses it
        do_reset();
        run_to(2);  NS_ped_raw = 1;
        run_to(4);  do_reset();
        run_to(20); chk("reset_mid_press", {1'b0, NS_ped_button}, 2'd0);
        NS_ped_raw = 1;
        run_to(26); chk("repress_e26", {1'b0, NS_ped_button}, 2'd0);
        run_to(27); chk("repress_e27", {1'b0, NS_ped_button}, 2'd1);
        NS_ped_raw = 0;

        // starvation with NS held red
        do_reset();
        NS_loop_raw = 1;
        run_to(5);  chk("ns_car_e5", {1'b0, NS_car_detect}, 2'd1);
        run_to(64); chk("starve_e64", {1'b0, NS_starved}, 2'd0);
`ifdef TRAFFIC_REQ_WATCHDOG_EN
        exp_starve = 2'd1;
`else
        exp_starve = 2'd0;
`endif
        run_to(65); chk("starve_e65", {1'b0, NS_starved}, exp_starve);
        NS_light = GRN;
        run_to(66); chk("starve_clr", {1'b0, NS_starved}, 2'd0);
        run_to(70);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
